clk_en_controller: RTL and testbench
====================================

# clk_en_controller

Run/halt/single-step sequencer for the system clock-enable. It replaces free-running fabric clock division with a programmable clock-enable strobe on the single `clk_in` domain. The strobe is issued at a configurable period. The processor core and peripherals gate their state updates on `clk_en`, so the design can run continuously, halt, or advance one enable at a time for debug.

## Interface
Parameters:
- `CNT_W`, 16, width of divisor and period counter.
- `DEFAULT_DIV`, 1, divisor loaded at reset. Enable period is `div+1` cycles, so 1 gives divide-by-2.
- `TICK_W`, 16, width of issued-enable counter.

Ports:
- `clk_in`, in, 1, system clock; the only clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `run`, in, 1, level request to enter RUN.
- `halt`, in, 1, level request to enter HALT; highest priority.
- `step`, in, 1, single-cycle request for exactly one enable from HALT.
- `cfg_valid`, in, 1, new divisor offered.
- `cfg_div`, in, CNT_W, new divisor value.
- `cfg_ready`, out, 1, divisor may be loaded; high only in HALT.
- `clk_en`, out, 1, one-cycle enable strobe.
- `mode`, out, 2, current state encoding.
- `tick_count`, out, TICK_W, number of `clk_en` pulses issued; wraps.

## Operation
- States: HALT (mode 0), RUN (mode 1), STEP (mode 2).
- Reset values:
  - state HALT, `div_q` = DEFAULT_DIV, counter 0.
  - `clk_en` 0, `tick_count` 0, `mode` 0, `cfg_ready` 1.
- HALT:
  - Counter held at 0.
  - Transitions are evaluated at the clock edge, with priority `halt` > `run` > `step`.
  - `run` moves to RUN. `step` moves to STEP.
- RUN:
  - Counter increments each cycle.
  - At counter == `div_q`: `clk_en`=1 and the counter returns to 0.
  - `halt` moves to HALT and clears the counter. `step` is ignored.
- STEP:
  - Counts as in RUN.
  - On the terminal-count cycle, `clk_en`=1, then the block returns to HALT.
  - `halt` before terminal count aborts the step with no pulse. `run` and `step` are ignored.
- `clk_en` is combinational: (state != HALT) && (counter == `div_q`).
- `tick_count` increments on every cycle with `clk_en`=1.
- Config handshake:
  - `cfg_ready` = (state == HALT).
  - When `cfg_valid && cfg_ready`, `div_q` <= `cfg_div` at the edge. The counter is already 0.
  - `cfg_valid` outside HALT is ignored: no load, nothing queued.
- Divisor 0 gives `clk_en` on every cycle in RUN. In STEP it gives a pulse in the first STEP cycle.
- Width rules:
  - Counter is CNT_W bits and compares equal to `div_q`; it never exceeds `div_q`.
  - `tick_count` wraps from 2^TICK_W-1 to 0.

## Timing
- Cycle numbering: `run` sampled at edge E moves to RUN from cycle E+1. The counter reads 0 in that cycle.
- First `clk_en` occurs in cycle E+1+`div_q`. After that, `clk_en` repeats every `div_q`+1 cycles.
- A load in the same HALT cycle as `run` uses the new divisor from the first RUN cycle.
- `halt` sampled at edge H: state is HALT and `clk_en` is 0 from cycle H+1. If `clk_en` was high in cycle H-1..H, that pulse still counts.
- STEP with `div_q`=d produces exactly one pulse in cycle E+1+d. `mode` returns to 0 in cycle E+2+d.
- `rst` assertion mid-RUN or mid-STEP forces the reset values immediately, asynchronously. On release, the block stays in HALT until a new request.

## Structure
- Package `clk_ctrl_pkg`:
  - `clk_mode_e` enum (HALT=0, RUN=1, STEP=2).
  - Default `CNT_W` and `TICK_W` constants.
- Sub-module `clk_en_counter`: terminal-count counter with inputs `clear`, `enable` and `limit`, and output `tc`.
- The FSM, config register and tick counter stay in the top module.

## Test plan
- Reset, then `run` with `div_q`=1 → `clk_en` high in every second cycle; the first pulse is 2 cycles after entering RUN; `tick_count` reaches 4 after 8 RUN cycles.
- In HALT, load `cfg_div`=3, then `run` → pulses every 4 cycles. A `cfg_valid` with 7 during RUN → `cfg_ready`=0, the period stays 4.
- `step` with `div_q`=2 → exactly one pulse, 3 cycles after entry, then `mode`=0. A second `step` gives one more pulse and `tick_count` increments by exactly 1.
- `halt` asserted in a STEP cycle before terminal count → no pulse, HALT next cycle, `tick_count` unchanged.
- `cfg_div`=0, `run` → `clk_en` constant 1. With TICK_W forced small (4), `tick_count` wraps 15→0.
- `rst` pulsed asynchronously mid-RUN (between edges) → `clk_en`, `tick_count` and `mode` go to 0 immediately, `div_q` returns to DEFAULT_DIV, and the block stays halted after release.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types and default widths for the clock-enable sequencer.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } clk_mode_e;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_TICK_W = 16;

endpackage : clk_ctrl_pkg

// File: rtl/clk_en_counter.sv
// Terminal-count counter: counts up while enabled, returns to 0 at limit.
module clk_en_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : clk_en_counter

// File: rtl/clk_en_controller.sv
// Run/halt/single-step sequencer producing a programmable clock-enable strobe.
module clk_en_controller
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 1,
  parameter int unsigned TICK_W      = DEF_TICK_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              clk_en,
  output logic [1:0]        mode,
  output logic [TICK_W-1:0] tick_count
);

  clk_mode_e         state_q, state_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tc;
  logic              cnt_clear;
  logic              cnt_enable;

  // Clearing on the next state keeps the counter at 0 throughout HALT and
  // on every exit into HALT, so a divisor load never sees a stale count.
  assign cnt_clear  = (state_d == HALT);
  assign cnt_enable = (state_q != HALT);

  clk_en_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (div_q),
    .tc     (tc)
  );

  assign clk_en     = (state_q != HALT) && tc;
  assign cfg_ready  = (state_q == HALT);
  assign mode       = state_q;
  assign tick_count = tick_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = clk_en ? tick_q + TICK_W'(1) : tick_q;

    unique case (state_q)
      HALT: begin
        if (cfg_valid) begin
          div_d = cfg_div;
        end
        if (halt) begin
          state_d = HALT;
        end else if (run) begin
          state_d = RUN;
        end else if (step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end
      end
      STEP: begin
        if (halt || tc) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= HALT;
      div_q   <= CNT_W'(DEFAULT_DIV);
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

endmodule : clk_en_controller

// File: tb/tb_clk_en_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle model.
module tb_clk_en_controller;

  localparam int unsigned TW  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned DEF = 1;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          run;
  logic          halt;
  logic          step;
  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic          clk_en;
  logic [1:0]    mode;
  logic [TW-1:0] tick_count;

  int errors = 0;
  int checks = 0;

  // Reference model: mode (0 halt, 1 run, 2 step), divisor, cycles since entry, pulses
  int          m_mode;
  int unsigned m_div;
  int unsigned m_el;
  int unsigned m_tick;
  int unsigned t0;

  clk_en_controller #(
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF),
    .TICK_W      (TW)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .run        (run),
    .halt       (halt),
    .step       (step),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .clk_en     (clk_en),
    .mode       (mode),
    .tick_count (tick_count)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic exp_en();
    return (m_mode != 0) && ((m_el % (m_div + 1)) == m_div);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_div  = DEF;
    m_el   = 0;
    m_tick = 0;
  endtask

  task automatic model_edge();
    logic pulse;
    pulse = exp_en();
    if (pulse) m_tick = (m_tick + 1) % (1 << TW);
    case (m_mode)
      0: begin
        if (cfg_valid) m_div = cfg_div;
        if (halt) m_mode = 0;
        else if (run) begin m_mode = 1; m_el = 0; end
        else if (step) begin m_mode = 2; m_el = 0; end
      end
      1: begin
        if (halt) m_mode = 0;
        else m_el++;
      end
      default: begin
        if (halt || pulse) m_mode = 0;
        else m_el++;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("clk_en",     32'(clk_en),     32'(exp_en()));
    check("mode",       32'(mode),       32'(m_mode));
    check("tick_count", 32'(tick_count), m_tick);
    check("cfg_ready",  32'(cfg_ready),  32'(m_mode == 0));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
    cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #2;
    check_all();
    #10 rst = 1'b0;

    // divide-by-2 from reset default
    run = 1'b1;
    cycle();
    run = 1'b0;
    repeat (8) cycle();
    check("tick_after_8_run", 32'(tick_count), 32'd4);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    check("halted_mode", 32'(mode), 32'd0);

    // load 3 together with run, then an ignored load while running
    cfg_valid = 1'b1; cfg_div = 16'd3; run = 1'b1;
    cycle();
    cfg_valid = 1'b0; run = 1'b0;
    repeat (6) cycle();
    cfg_valid = 1'b1; cfg_div = 16'd7;
    check("cfg_ready_in_run", 32'(cfg_ready), 32'd0);
    repeat (12) cycle();
    cfg_valid = 1'b0; halt = 1'b1;
    cycle();
    halt = 1'b0;

    // single steps with divisor 2
    cfg_valid = 1'b1; cfg_div = 16'd2;
    cycle();
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t0 = 32'(tick_count);
      step = 1'b1;
      cycle();
      step = 1'b0;
      repeat (4) cycle();
      check("step_mode_back", 32'(mode), 32'd0);
      check("step_one_tick", 32'(tick_count), (t0 + 1) % (1 << TW));
    end

    // halt aborts a step before terminal count
    t0 = 32'(tick_count);
    step = 1'b1;
    cycle();
    step = 1'b0; halt = 1'b1;
    cycle();
    halt = 1'b0;
    cycle();
    check("abort_mode", 32'(mode), 32'd0);
    check("abort_no_tick", 32'(tick_count), t0);

    // divisor 0: enable every cycle, tick counter wraps
    cfg_valid = 1'b1; cfg_div = '0; run = 1'b1;
    cycle();
    cfg_valid = 1'b0; run = 1'b0;
    repeat (20) cycle();
    check("div0_constant_en", 32'(clk_en), 32'd1);
    halt = 1'b1;
    cycle();
    halt = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      halt      = ($urandom % 12) == 0;
      run       = ($urandom % 7) == 0;
      step      = ($urandom % 5) == 0;
      cfg_valid = ($urandom % 3) == 0;
      cfg_div   = CW'($urandom % 5);
      cycle();
    end

    // asynchronous reset mid-run
    halt = 1'b0; step = 1'b0;
    cfg_valid = 1'b1; cfg_div = 16'd3; run = 1'b1;
    cycle();
    cycle();
    cfg_valid = 1'b0; run = 1'b0;
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_tick", 32'(tick_count), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    #3 rst = 1'b0;
    repeat (3) cycle();
    run = 1'b1;
    cycle();
    run = 1'b0;
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_en_controller
